// File: rtl/iqft3_seq_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iqft3_seq_decoder_pkg
// Brief    : Shared S3.4 fixed-point constants, IQFT twiddle ROM and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package iqft3_seq_decoder_pkg;

    localparam int TOTAL_WIDTH = 8;
    localparam int FRAC        = 4;
    localparam int COEF_W      = 10;
    localparam int COEF_FRAC   = 8;
    localparam int NPTS        = 8;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    // W[m] = e^(-i*pi*m/4) / sqrt(8), scaled by 2^COEF_FRAC
    function automatic logic signed [COEF_W-1:0] tw_re(input logic [2:0] m);
        logic signed [COEF_W-1:0] r;
        case (m)
            3'd0:    r =  10'sd91;
            3'd1:    r =  10'sd64;
            3'd2:    r =  10'sd0;
            3'd3:    r = -10'sd64;
            3'd4:    r = -10'sd91;
            3'd5:    r = -10'sd64;
            3'd6:    r =  10'sd0;
            default: r =  10'sd64;
        endcase
        return r;
    endfunction

    function automatic logic signed [COEF_W-1:0] tw_im(input logic [2:0] m);
        logic signed [COEF_W-1:0] r;
        case (m)
            3'd0:    r =  10'sd0;
            3'd1:    r = -10'sd64;
            3'd2:    r = -10'sd91;
            3'd3:    r = -10'sd64;
            3'd4:    r =  10'sd0;
            3'd5:    r =  10'sd64;
            3'd6:    r =  10'sd91;
            default: r =  10'sd64;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iqft3_seq_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : iqft3_seq_decoder_if
// Brief    : Input/output amplitude streams of the sequential IQFT decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface iqft3_seq_decoder_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_r;
    logic signed [DATA_W-1:0] in_i;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_r;
    logic signed [DATA_W-1:0] out_i;
    logic [2:0]               out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/iqft3_seq_decoder_cmul_sat_round.sv
`default_nettype none
// ============================================================================
// Module   : iqft3_seq_decoder_cmul_sat_round
// Brief    : Full-width complex multiply plus round-half-up / saturate back to S3.4.
// Revision : 1.0 - initial release
// ============================================================================
module iqft3_seq_decoder_cmul_sat_round #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 10,
    parameter int COEF_FRAC = 8,
    parameter int ACC_W     = 22,
    parameter int PROD_W    = DATA_W + COEF_W + 1
) (
    input  logic signed [DATA_W-1:0] fr_i,
    input  logic signed [DATA_W-1:0] fi_i,
    input  logic signed [COEF_W-1:0] wr_i,
    input  logic signed [COEF_W-1:0] wi_i,
    output logic signed [PROD_W-1:0] pr_o,
    output logic signed [PROD_W-1:0] pi_o,
    input  logic signed [ACC_W-1:0]  acc_r_i,
    input  logic signed [ACC_W-1:0]  acc_i_i,
    output logic signed [DATA_W-1:0] res_r_o,
    output logic signed [DATA_W-1:0] res_i_o
);
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    logic signed [PROD_W-1:0] fr_x, fi_x, wr_x, wi_x;

    assign fr_x = PROD_W'(fr_i);
    assign fi_x = PROD_W'(fi_i);
    assign wr_x = PROD_W'(wr_i);
    assign wi_x = PROD_W'(wi_i);

    assign pr_o = (fr_x * wr_x) - (fi_x * wi_x);
    assign pi_o = (fr_x * wi_x) + (fi_x * wr_x);

    function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = (a + HALF) >>> COEF_FRAC;
        if (s > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return s[DATA_W-1:0];
    endfunction

    assign res_r_o = sat_round(acc_r_i);
    assign res_i_o = sat_round(acc_i_i);

endmodule
`default_nettype wire

// File: rtl/iqft3_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : iqft3_seq_decoder
// Brief    : Sequential 8-point inverse QFT with one time-multiplexed complex MAC.
// Revision : 1.0 - initial release
// ============================================================================
module iqft3_seq_decoder #(
    parameter int DATA_W    = iqft3_seq_decoder_pkg::TOTAL_WIDTH,
    parameter int COEF_W    = iqft3_seq_decoder_pkg::COEF_W,
    parameter int COEF_FRAC = iqft3_seq_decoder_pkg::COEF_FRAC,
    parameter int ACC_W     = DATA_W + COEF_W + 4
) (
    input  logic               clk,
    input  logic               rst_n,
    iqft3_seq_decoder_if.slave bus,
    output logic               busy_o
);
    import iqft3_seq_decoder_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W + 1;

    state_e state_q, state_d;

    logic [2:0]               in_k_q;
    logic [6:0]               cnt_q;
    logic [2:0]               out_idx_q;
    logic signed [DATA_W-1:0] ibuf_r_q [NPTS];
    logic signed [DATA_W-1:0] ibuf_i_q [NPTS];
    logic signed [DATA_W-1:0] obuf_r_q [NPTS];
    logic signed [DATA_W-1:0] obuf_i_q [NPTS];
    logic                     p_vld_q;
    logic                     p_last_q;
    logic [2:0]               p_n_q;
    logic signed [PROD_W-1:0] prod_r_q, prod_i_q;
    logic signed [ACC_W-1:0]  acc_r_q, acc_i_q;

    logic                     in_hs, out_hs, issue, out_valid;
    logic [2:0]               mac_n, mac_k, tw_m;
    logic signed [COEF_W-1:0] tw_r, tw_i;
    logic signed [PROD_W-1:0] prod_r, prod_i;
    logic signed [ACC_W-1:0]  acc_r_next, acc_i_next;
    logic signed [DATA_W-1:0] res_r, res_i;

    assign in_hs     = (state_q == ST_LOAD) && bus.in_valid;
    assign out_valid = (state_q == ST_OUTPUT);
    assign out_hs    = out_valid && bus.out_ready;

    // cnt_q = {n,k}; bit 6 marks that all 64 terms have been issued
    assign issue = (state_q == ST_COMPUTE) && !cnt_q[6];
    assign mac_n = cnt_q[5:3];
    assign mac_k = cnt_q[2:0];
    assign tw_m  = mac_n * mac_k;
    assign tw_r  = COEF_W'(tw_re(tw_m));
    assign tw_i  = COEF_W'(tw_im(tw_m));

    assign acc_r_next = acc_r_q + {{(ACC_W-PROD_W){prod_r_q[PROD_W-1]}}, prod_r_q};
    assign acc_i_next = acc_i_q + {{(ACC_W-PROD_W){prod_i_q[PROD_W-1]}}, prod_i_q};

    iqft3_seq_decoder_cmul_sat_round #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W),
        .PROD_W    (PROD_W)
    ) u_cmul (
        .fr_i    (ibuf_r_q[mac_k]),
        .fi_i    (ibuf_i_q[mac_k]),
        .wr_i    (tw_r),
        .wi_i    (tw_i),
        .pr_o    (prod_r),
        .pi_o    (prod_i),
        .acc_r_i (acc_r_next),
        .acc_i_i (acc_i_next),
        .res_r_o (res_r),
        .res_i_o (res_i)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (in_hs && (in_k_q == 3'd7)) state_d = ST_COMPUTE;
            ST_COMPUTE: if (p_vld_q && p_last_q && (p_n_q == 3'd7)) state_d = ST_OUTPUT;
            ST_OUTPUT:  if (out_hs && (out_idx_q == 3'd7)) state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_k_q <= '0;
            for (int i = 0; i < NPTS; i++) begin
                ibuf_r_q[i] <= '0;
                ibuf_i_q[i] <= '0;
            end
        end else if (in_hs) begin
            ibuf_r_q[in_k_q] <= bus.in_r;
            ibuf_i_q[in_k_q] <= bus.in_i;
            in_k_q           <= in_k_q + 3'd1;
        end
    end

    // Products are registered before accumulation, so the last result lands
    // one cycle after the final issue and the FSM leaves COMPUTE on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            p_vld_q  <= 1'b0;
            p_last_q <= 1'b0;
            p_n_q    <= '0;
            prod_r_q <= '0;
            prod_i_q <= '0;
            acc_r_q  <= '0;
            acc_i_q  <= '0;
            for (int i = 0; i < NPTS; i++) begin
                obuf_r_q[i] <= '0;
                obuf_i_q[i] <= '0;
            end
        end else if (state_q != ST_COMPUTE) begin
            cnt_q   <= '0;
            p_vld_q <= 1'b0;
            acc_r_q <= '0;
            acc_i_q <= '0;
        end else begin
            if (issue) begin
                cnt_q <= cnt_q + 7'd1;
            end
            p_vld_q  <= issue;
            p_last_q <= (mac_k == 3'd7);
            p_n_q    <= mac_n;
            prod_r_q <= prod_r;
            prod_i_q <= prod_i;
            if (p_vld_q) begin
                if (p_last_q) begin
                    obuf_r_q[p_n_q] <= res_r;
                    obuf_i_q[p_n_q] <= res_i;
                    acc_r_q         <= '0;
                    acc_i_q         <= '0;
                end else begin
                    acc_r_q <= acc_r_next;
                    acc_i_q <= acc_i_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_q <= '0;
        end else if (!out_valid) begin
            out_idx_q <= '0;
        end else if (out_hs) begin
            out_idx_q <= out_idx_q + 3'd1;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = out_valid;
    assign bus.out_r     = out_valid ? obuf_r_q[out_idx_q] : '0;
    assign bus.out_i     = out_valid ? obuf_i_q[out_idx_q] : '0;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_valid && (out_idx_q == 3'd7);
    assign busy_o        = (state_q == ST_COMPUTE) || (state_q == ST_OUTPUT);

endmodule
`default_nettype wire

// File: tb/tb_iqft3_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_iqft3_seq_decoder
// Brief    : Directed self-checking bench for the sequential IQFT decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iqft3_seq_decoder;
    localparam int DATA_W = 8;

    typedef int frame_t [8];

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    frame_t zero_f, six_f, imp_r, rt_r, rt_i, rt_er, pos_f, pos_e, neg_f, neg_e;

    iqft3_seq_decoder_if #(.DATA_W(DATA_W)) bus ();

    iqft3_seq_decoder #(.DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the active edge; with stall set, every
    // beat is preceded by an idle cycle carrying junk data.
    task automatic send_frame(input frame_t fr, input frame_t fi, input bit stall);
        for (int k = 0; k < 8; k++) begin
            if (stall) begin
                bus.in_valid = 1'b0;
                bus.in_r     = 8'sd99;
                bus.in_i     = -8'sd77;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_r     = 8'(fr[k]);
            bus.in_i     = 8'(fi[k]);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_r     = '0;
        bus.in_i     = '0;
    endtask

    task automatic wait_output(input string tag);
        int c;
        bit ready_seen;
        bit busy_low;
        c          = 0;
        ready_seen = 1'b0;
        busy_low   = 1'b0;
        while (!bus.out_valid && c < 200) begin
            if (bus.in_ready) ready_seen = 1'b1;
            if (!busy) busy_low = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        chk($sformatf("%s latency", tag), c, 65);
        chk($sformatf("%s in_ready during compute", tag), ready_seen, 0);
        chk($sformatf("%s busy during compute", tag), busy_low, 0);
    endtask

    task automatic recv_frame(input string tag, input frame_t er, input frame_t ei, input int stall_idx);
        bit ready_seen;
        ready_seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("%s[%0d] valid", tag, n), bus.out_valid, 1);
            chk($sformatf("%s[%0d] idx", tag, n), bus.out_idx, n);
            chk($sformatf("%s[%0d] re", tag, n), bus.out_r, er[n]);
            chk($sformatf("%s[%0d] im", tag, n), bus.out_i, ei[n]);
            chk($sformatf("%s[%0d] last", tag, n), bus.out_last, (n == 7) ? 1 : 0);
            if (bus.in_ready) ready_seen = 1'b1;
            if (n == stall_idx) begin
                bit moved;
                moved         = 1'b0;
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    if (!bus.out_valid || bus.out_idx !== 3'(n) ||
                        bus.out_r !== 8'(er[n]) || bus.out_i !== 8'(ei[n]))
                        moved = 1'b1;
                end
                chk($sformatf("%s[%0d] hold stable", tag, n), moved, 0);
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("%s in_ready during output", tag), ready_seen, 0);
        chk($sformatf("%s valid after last", tag), bus.out_valid, 0);
        chk($sformatf("%s in_ready after last", tag), bus.in_ready, 1);
        chk($sformatf("%s busy after last", tag), busy, 0);
    endtask

    initial begin
        zero_f = '{default: 0};
        six_f  = '{default: 6};
        imp_r  = '{16, 0, 0, 0, 0, 0, 0, 0};
        rt_r   = '{6, 0, -6, 0, 6, 0, -6, 0};
        rt_i   = '{0, -6, 0, 6, 0, -6, 0, 6};
        rt_er  = '{0, 0, 0, 0, 0, 0, 17, 0};
        pos_f  = '{default: 127};
        pos_e  = '{127, 0, 0, 0, 0, 0, 0, 0};
        neg_f  = '{default: -128};
        neg_e  = '{-128, 0, 0, 0, 0, 0, 0, 0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_r", bus.out_r, 0);
        chk("reset out_i", bus.out_i, 0);
        chk("reset out_idx", bus.out_idx, 0);
        chk("reset out_last", bus.out_last, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_frame(imp_r, zero_f, 1'b0);
        wait_output("impulse");
        recv_frame("impulse", six_f, zero_f, -1);

        send_frame(rt_r, rt_i, 1'b0);
        wait_output("roundtrip");
        recv_frame("roundtrip", rt_er, zero_f, 3);

        send_frame(pos_f, zero_f, 1'b0);
        wait_output("sat_pos");
        recv_frame("sat_pos", pos_e, zero_f, -1);

        send_frame(neg_f, zero_f, 1'b0);
        wait_output("sat_neg");
        recv_frame("sat_neg", neg_e, zero_f, -1);

        send_frame(imp_r, zero_f, 1'b1);
        wait_output("in_stall");
        recv_frame("in_stall", six_f, zero_f, -1);

        send_frame(pos_f, pos_f, 1'b0);
        repeat (30) begin
            @(posedge clk); #1;
        end
        chk("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset in_ready", bus.in_ready, 1);
        chk("mid reset out_valid", bus.out_valid, 0);
        chk("mid reset busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset in_ready", bus.in_ready, 1);
        chk("post reset busy", busy, 0);

        send_frame(imp_r, zero_f, 1'b0);
        wait_output("after_reset");
        recv_frame("after_reset", six_f, zero_f, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iqft3_seq_decoder.md
Name: iqft3_seq_decoder

Overview:
Sequential inverse 3-qubit QFT: the decoder counterpart of qft3_top_pipelined. It accepts one 8-amplitude complex frame serially over a valid/ready stream and computes a[n] = Σk F[k]·e^(−iπnk/4)/√8 with a single time-multiplexed complex MAC. It then returns the 8 decoded amplitudes serially. It sits after the QFT core for round-trip checking and state recovery, using the same S3.4 fixed-point format from fixed_point_params.vh.

Parameters:
DATA_W, `TOTAL_WIDTH (8), signed amplitude width, S3.4 format
COEF_W, 10, signed twiddle-coefficient width
COEF_FRAC, 8, twiddle fraction bits (1/√8 is stored as 91)
ACC_W, DATA_W+COEF_W+4, signed accumulator width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input amplitude valid
in_ready  out  1  core can accept an input amplitude
in_r  in  DATA_W  real part of F[k]; k is implicit, 0..7 in arrival order
in_i  in  DATA_W  imaginary part of F[k]
out_valid  out  1  decoded amplitude valid
out_ready  in  1  downstream accepts the output
out_r  out  DATA_W  real part of a[n]
out_i  out  DATA_W  imaginary part of a[n]
out_idx  out  3  n of the current output
out_last  out  1  high with n==7
busy  out  1  high in COMPUTE or OUTPUT

Behaviour:
- Reset (asynchronous, rst_n low): state=LOAD; counters=0; accumulator=0; in_ready=1; out_valid=0; out_r/out_i/out_idx=0; out_last=0; busy=0. Reset mid-frame discards all partial data and results.
- FSM LOAD → COMPUTE → OUTPUT → LOAD. There is no frame overlap.
- LOAD:
  - in_ready=1. Each in_valid&in_ready beat writes ibuf[k] and increments k.
  - The beat with k==7 moves the FSM to COMPUTE on the next edge.
- COMPUTE:
  - Exactly 64 cycles, in_ready=0. Counter (n,k) steps k fastest.
  - Each cycle: m=(n·k) mod 8; prod = ibuf[k]·W[m], full width; acc_next = acc + prod.
  - When k==7: result = sat(round(acc_next)) is written to obuf[n] and acc cleared. Otherwise acc is updated with acc_next.
- Twiddle ROM W[m] = e^(−iπm/4)·91/256 as (re,im):
  - m=0: (91,0); m=1: (64,−64); m=2: (0,−91); m=3: (−64,−64)
  - m=4: (−91,0); m=5: (−64,64); m=6: (0,91); m=7: (64,64)
- Complex product: re = fr·wr − fi·wi; im = fr·wi + fi·wr.
- Rounding: add 2^(COEF_FRAC−1), then arithmetic shift right by COEF_FRAC (round half up). Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- OUTPUT:
  - out_valid=1; out_r/out_i = obuf[idx]; out_idx=idx; out_last=(idx==7).
  - Data is held stable while out_ready=0. Each handshake advances idx.
  - The handshake at idx==7 returns the FSM to LOAD: out_valid=0 and in_ready=1 on the next cycle.
- Latency: last input beat accepted at edge t → out_valid high after edge t+65 (64 compute cycles plus the state register).
- in_valid during COMPUTE or OUTPUT is ignored (in_ready=0).

Decomposition:
- Shared package/header (fixed_point_params.vh): TOTAL_WIDTH, FRAC, COEF_W, COEF_FRAC, and the 8-entry twiddle ROM constants. The same ROM is reused by any future QFT/IQFT variants.
- One natural sub-module: cmul_sat_round. It holds the complex multiply and the round/saturate function, and is shared with the pipelined QFT rotation stages.

Test Plan:
- Impulse: frame F[0]=(16,0), rest (0,0) → all 8 outputs (6,0); out_idx 0..7; out_last only on idx 7.
- Round trip: frame (6,0),(0,−6),(−6,0),(0,6),(6,0),(0,−6),(−6,0),(0,6) → a[6]=(17,0), all other a[n]=(0,0) (recovers |110>).
- Saturation: all F[k]=(127,0) → a[0]=(127,0), others (0,0). All F[k]=(−128,0) → a[0]=(−128,0), others (0,0).
- Latency/backpressure:
  - out_valid rises exactly 65 cycles after the 8th input handshake.
  - Hold out_ready=0 for 5 cycles at idx 3 → out_r/out_i/out_idx stay stable and no index is skipped.
  - in_ready=0 throughout COMPUTE/OUTPUT.
- Input stalls: in_valid toggled 1/0 during LOAD → only handshaken beats are counted; the result matches the impulse case.
- Reset mid-COMPUTE (cycle 30) → next cycle in_ready=1, out_valid=0, busy=0. A subsequent impulse frame produces all (6,0).
